// File: rtl/controle_senha_pkg.sv
// Shared types for the password-lock controller.
// Holds the FSM state codes and the digit width.
package controle_senha_pkg;

    localparam int LARGURA_DIGITO = 4;

    typedef enum logic [3:0] {
        S_INICIAL       = 4'd0,
        S_ESPERA_DADO   = 4'd1,
        S_ARMAZENA_DADO = 4'd2,
        S_COMPARA_SENHA = 4'd3,
        S_ABERTO        = 4'd4,
        S_FALHA         = 4'd5,
        S_BLOQUEADO     = 4'd6
    } estado_t;

    // Debug code of a state; anything outside the known set reads as F.
    function automatic logic [3:0] codigo_estado(input estado_t e);
        logic [3:0] c;
        case (e)
            S_INICIAL:       c = 4'd0;
            S_ESPERA_DADO:   c = 4'd1;
            S_ARMAZENA_DADO: c = 4'd2;
            S_COMPARA_SENHA: c = 4'd3;
            S_ABERTO:        c = 4'd4;
            S_FALHA:         c = 4'd5;
            S_BLOQUEADO:     c = 4'd6;
            default:         c = 4'hF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/controle_senha_contador_tempo.sv
// Down-counter shared by the open and lockout intervals.
// Ports: clk, rst_n, carrega/valor (load), fim (count is zero).
module contador_tempo
    import controle_senha_pkg::*;
#(
    parameter int LARGURA = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               carrega,
    input  logic [LARGURA-1:0] valor,
    output logic               fim
);

    logic [LARGURA-1:0] cont_q;
    logic [LARGURA-1:0] cont_d;

    // Load wins over counting; the count holds once it reaches zero.
    always_comb begin
        cont_d = cont_q;
        if (carrega) begin
            cont_d = valor;
        end else if (cont_q != '0) begin
            cont_d = cont_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign fim = (cont_q == '0);

endmodule

// File: rtl/controle_senha.sv
// Password-lock controller: buffers digits, compares on confirm,
// opens the servo or counts failures and locks out.
// Ports: clock, reset (async, active-low), fimRecepcao/comando/dado
// from the receiver; abrir, bloqueado, erro, numDigitos, dbEstado.
module controle_senha
    import controle_senha_pkg::*;
#(
    parameter int                            DIGITOS    = 4,
    parameter logic [DIGITOS*4-1:0]          SENHA      = 16'h1234,
    parameter int                            T_ABERTO   = 50_000_000,
    parameter int                            T_BLOQUEIO = 250_000_000,
    parameter int                            MAX_ERROS  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fimRecepcao,
    input  logic       comando,
    input  logic [3:0] dado,
    output logic       abrir,
    output logic       bloqueado,
    output logic       erro,
    output logic [2:0] numDigitos,
    output logic [3:0] dbEstado
);

    localparam int LARG_BUF   = DIGITOS * LARGURA_DIGITO;
    localparam int T_MAX      = (T_ABERTO > T_BLOQUEIO) ?
                                T_ABERTO : T_BLOQUEIO;
    localparam int LARG_TEMPO = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int LARG_ERROS = (MAX_ERROS > 0) ?
                                $clog2(MAX_ERROS + 1) : 1;

    localparam logic [2:0] NUM_SATURA = 3'(DIGITOS + 1);
    localparam logic [2:0] NUM_CHEIO  = 3'(DIGITOS);

    localparam logic [LARG_TEMPO-1:0] V_ABERTO =
        LARG_TEMPO'(T_ABERTO - 1);
    localparam logic [LARG_TEMPO-1:0] V_BLOQUEIO =
        LARG_TEMPO'(T_BLOQUEIO - 1);
    localparam logic [LARG_ERROS-1:0] ERROS_LIMITE =
        LARG_ERROS'(MAX_ERROS);

    estado_t                 estado_q;
    estado_t                 estado_d;
    logic [LARG_BUF-1:0]     buffer_q;
    logic [LARG_BUF-1:0]     buffer_d;
    logic [2:0]              num_q;
    logic [2:0]              num_d;
    logic [LARG_ERROS-1:0]   erros_q;
    logic [LARG_ERROS-1:0]   erros_d;
    logic [LARG_ERROS-1:0]   erros_inc;
    logic [3:0]              dado_q;
    logic [3:0]              dado_d;

    logic                    carrega;
    logic [LARG_TEMPO-1:0]   valor;
    logic                    fim_tempo;

    contador_tempo #(
        .LARGURA (LARG_TEMPO)
    ) u_tempo (
        .clk     (clock),
        .rst_n   (reset),
        .carrega (carrega),
        .valor   (valor),
        .fim     (fim_tempo)
    );

    assign erros_inc = erros_q + 1'b1;

    always_comb begin
        estado_d = estado_q;
        buffer_d = buffer_q;
        num_d    = num_q;
        erros_d  = erros_q;
        dado_d   = dado_q;
        carrega  = 1'b0;
        valor    = V_ABERTO;

        case (estado_q)
            S_INICIAL: begin
                buffer_d = '0;
                num_d    = '0;
                erros_d  = '0;
                estado_d = S_ESPERA_DADO;
            end

            S_ESPERA_DADO: begin
                if (fimRecepcao) begin
                    if (comando) begin
                        estado_d = S_COMPARA_SENHA;
                    end else begin
                        // dado is only valid during the pulse, so
                        // hold it for the store cycle.
                        dado_d   = dado;
                        estado_d = S_ARMAZENA_DADO;
                    end
                end
            end

            S_ARMAZENA_DADO: begin
                buffer_d = {buffer_q[LARG_BUF-LARGURA_DIGITO-1:0],
                            dado_q};
                // Saturating one past full marks an overlong entry.
                if (num_q != NUM_SATURA) begin
                    num_d = num_q + 1'b1;
                end
                estado_d = S_ESPERA_DADO;
            end

            S_COMPARA_SENHA: begin
                buffer_d = '0;
                num_d    = '0;
                if (num_q == NUM_CHEIO && buffer_q == SENHA) begin
                    erros_d  = '0;
                    carrega  = 1'b1;
                    valor    = V_ABERTO;
                    estado_d = S_ABERTO;
                end else begin
                    estado_d = S_FALHA;
                end
            end

            S_ABERTO: begin
                if (fim_tempo || (fimRecepcao && comando)) begin
                    estado_d = S_ESPERA_DADO;
                end
            end

            S_FALHA: begin
                erros_d = erros_inc;
                if (erros_inc == ERROS_LIMITE) begin
                    carrega  = 1'b1;
                    valor    = V_BLOQUEIO;
                    estado_d = S_BLOQUEADO;
                end else begin
                    estado_d = S_ESPERA_DADO;
                end
            end

            S_BLOQUEADO: begin
                if (fim_tempo) begin
                    erros_d  = '0;
                    estado_d = S_ESPERA_DADO;
                end
            end

            default: begin
                estado_d = S_INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= S_INICIAL;
            buffer_q <= '0;
            num_q    <= '0;
            erros_q  <= '0;
            dado_q   <= '0;
        end else begin
            estado_q <= estado_d;
            buffer_q <= buffer_d;
            num_q    <= num_d;
            erros_q  <= erros_d;
            dado_q   <= dado_d;
        end
    end

    // All outputs come straight from registered state.
    assign abrir      = (estado_q == S_ABERTO);
    assign bloqueado  = (estado_q == S_BLOQUEADO);
    assign erro       = (estado_q == S_FALHA);
    assign numDigitos = num_q;
    assign dbEstado   = codigo_estado(estado_q);

endmodule

// File: tb/tb_controle_senha.sv
// Bench for controle_senha with short open/lockout times.
// Table of entry/confirm vectors plus lockout, close and reset runs.
module tb_controle_senha;

    typedef enum int { EV_OPEN, EV_ERR, EV_LOCK } ev_t;

    typedef struct {
        int              n;
        logic [0:5][3:0] d;
        ev_t             ev;
    } rec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       fimRecepcao = 1'b0;
    logic       comando = 1'b0;
    logic [3:0] dado = 4'd0;
    logic       abrir;
    logic       bloqueado;
    logic       erro;
    logic [2:0] numDigitos;
    logic [3:0] dbEstado;

    int  n_vec = 0;
    int  n_err = 0;
    ev_t q[$];
    bit  abort_len = 1'b0;
    bit  lock_ok = 1'b0;

    controle_senha #(
        .T_ABERTO   (8),
        .T_BLOQUEIO (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fimRecepcao (fimRecepcao),
        .comando     (comando),
        .dado        (dado),
        .abrir       (abrir),
        .bloqueado   (bloqueado),
        .erro        (erro),
        .numDigitos  (numDigitos),
        .dbEstado    (dbEstado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input logic c, input logic [3:0] d);
        @(posedge clock);
        #1;
        fimRecepcao = 1'b1;
        comando     = c;
        dado        = d;
        @(posedge clock);
        #1;
        fimRecepcao = 1'b0;
        comando     = 1'b0;
        dado        = 4'd0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (dbEstado == 4'd1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input rec_t r, input bit wait_done);
        for (int i = 0; i < r.n; i++) begin
            send(1'b0, r.d[i]);
            @(negedge clock);
            chk("store_state", 32'(dbEstado), 32'd2);
            @(negedge clock);
            chk("ndig", 32'(numDigitos), (i + 1 > 5) ? 5 : i + 1);
        end
        send(1'b1, 4'd0);
        q.push_back(r.ev);
        @(negedge clock);
        chk("cmp_state", 32'(dbEstado), 32'd3);
        @(negedge clock);
        chk("res_state", 32'(dbEstado),
            (r.ev == EV_OPEN) ? 32'd4 : 32'd5);
        chk("ndig_clr", 32'(numDigitos), 32'd0);
        if (r.ev == EV_LOCK) begin
            @(negedge clock);
            chk("lock_state", 32'(dbEstado), 32'd6);
        end else if (r.ev == EV_ERR) begin
            @(negedge clock);
            chk("err_ret", 32'(dbEstado), 32'd1);
        end
        if (wait_done) wait_idle();
    endtask

    // Event monitor: pops the scoreboard on abrir rise / erro pulse
    // and checks pulse widths.
    bit abrir_p = 1'b0;
    bit erro_p  = 1'b0;
    bit blk_p   = 1'b0;
    int ab_len  = 0;
    int blk_len = 0;

    always @(negedge clock) begin
        ev_t ev;
        if (abrir) ab_len++;
        if (bloqueado) blk_len++;
        if (abrir && !abrir_p) begin
            if (q.size() == 0) begin
                chk("abrir_unexpected", 32'd1, 32'd0);
            end else begin
                ev = q.pop_front();
                chk("abrir_kind", 32'(ev), 32'(EV_OPEN));
            end
        end
        if (!abrir && abrir_p) begin
            if (!abort_len) chk("abrir_len", 32'(ab_len), 32'd8);
            abort_len = 1'b0;
            ab_len = 0;
        end
        if (erro) begin
            if (erro_p) chk("erro_width", 32'd2, 32'd1);
            if (q.size() == 0) begin
                chk("erro_unexpected", 32'd1, 32'd0);
            end else begin
                ev = q.pop_front();
                chk("erro_kind", 32'(ev != EV_OPEN), 32'd1);
                if (ev == EV_LOCK) lock_ok = 1'b1;
            end
        end
        if (bloqueado && !blk_p) begin
            chk("lock_expected", 32'(lock_ok), 32'd1);
            lock_ok = 1'b0;
        end
        if (!bloqueado && blk_p) begin
            chk("bloq_len", 32'(blk_len), 32'd16);
            blk_len = 0;
        end
        abrir_p = abrir;
        erro_p  = erro;
        blk_p   = bloqueado;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    rec_t vt[11];
    rec_t r;

    initial begin
        vt[0]  = '{4, 24'h123400, EV_OPEN};
        vt[1]  = '{4, 24'h123500, EV_ERR};
        vt[2]  = '{5, 24'h912340, EV_ERR};
        vt[3]  = '{4, 24'h123400, EV_OPEN};
        vt[4]  = '{4, 24'h000000, EV_ERR};
        vt[5]  = '{4, 24'h432100, EV_ERR};
        vt[6]  = '{4, 24'h123400, EV_OPEN};
        vt[7]  = '{6, 24'h561234, EV_ERR};
        vt[8]  = '{3, 24'h123000, EV_ERR};
        vt[9]  = '{0, 24'h000000, EV_LOCK};
        vt[10] = '{4, 24'h123400, EV_OPEN};

        #12;
        chk("rst_abrir", 32'(abrir), 32'd0);
        chk("rst_bloq", 32'(bloqueado), 32'd0);
        chk("rst_erro", 32'(erro), 32'd0);
        chk("rst_ndig", 32'(numDigitos), 32'd0);
        chk("rst_state", 32'(dbEstado), 32'd0);
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        chk("boot_state", 32'(dbEstado), 32'd1);

        for (int i = 0; i < 11; i++) run_vec(vt[i], 1'b1);

        // Lockout with a correct entry arriving during it.
        r = '{4, 24'h123500, EV_ERR};
        run_vec(r, 1'b1);
        r = '{4, 24'h111100, EV_ERR};
        run_vec(r, 1'b1);
        r = '{4, 24'h222200, EV_LOCK};
        run_vec(r, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send(1'b0, 4'(k + 1));
            @(negedge clock);
            @(negedge clock);
            chk("lock_ndig", 32'(numDigitos), 32'd0);
        end
        send(1'b1, 4'd0);
        @(negedge clock);
        @(negedge clock);
        chk("lock_hold", 32'(bloqueado), 32'd1);
        chk("lock_noopen", 32'(abrir), 32'd0);
        wait_idle();
        r = '{4, 24'h123400, EV_OPEN};
        run_vec(r, 1'b1);

        // Digit ignored while open, then early close.
        run_vec(r, 1'b0);
        send(1'b0, 4'd7);
        @(negedge clock);
        @(negedge clock);
        chk("open_ndig", 32'(numDigitos), 32'd0);
        chk("open_hold", 32'(abrir), 32'd1);
        abort_len = 1'b1;
        send(1'b1, 4'd0);
        @(negedge clock);
        chk("close_abrir", 32'(abrir), 32'd0);
        chk("close_state", 32'(dbEstado), 32'd1);

        // Asynchronous reset in the middle of the open interval.
        run_vec(r, 1'b0);
        @(negedge clock);
        abort_len = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_abrir", 32'(abrir), 32'd0);
        chk("mid_rst_state", 32'(dbEstado), 32'd0);
        chk("mid_rst_ndig", 32'(numDigitos), 32'd0);
        chk("mid_rst_bloq", 32'(bloqueado), 32'd0);
        @(negedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("post_rst_state", 32'(dbEstado), 32'd1);

        repeat (4) @(negedge clock);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
